// File: rtl/frontend_mode_ctrl.sv
// TVP7002 frontend mode tracker: lock/acquire FSM, sticky mode irq, frame-aligned shadow config commit.
// Optional macro FRONTEND_MODE_CTRL_AUTO_BLANK_EN adds a registered blank_o output.
module frontend_mode_ctrl #(
  parameter int unsigned STABLE_FRAMES   = 4,
  parameter int unsigned MISMATCH_FRAMES = 2,
  parameter int unsigned PCNT_TOL        = 64
) (
  input  logic        PCLK_i,
  input  logic        reset_n,
  input  logic        frame_change_i,
  input  logic        sync_active_i,
  input  logic        interlace_flag_i,
  input  logic [10:0] vtotal_i,
  input  logic [19:0] pcnt_field_i,
  input  logic        cfg_wr_i,
  input  logic [1:0]  cfg_sel_i,
  input  logic [31:0] cfg_data_i,
  input  logic        commit_req_i,
  input  logic        irq_clr_i,
  output logic [31:0] hv_in_config_o,
  output logic [31:0] hv_in_config2_o,
  output logic [31:0] hv_in_config3_o,
  output logic [31:0] misc_config_o,
  output logic        commit_busy_o,
  output logic        commit_done_o,
  output logic [1:0]  state_o,
  output logic        irq_o,
  output logic [10:0] lock_vtotal_o,
  output logic        lock_interlace_o,
  output logic [19:0] lock_pcnt_field_o
`ifdef FRONTEND_MODE_CTRL_AUTO_BLANK_EN
  ,
  output logic        blank_o
`endif
);

  typedef enum logic [1:0] {
    NOSYNC  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [3:0]  STABLE_W   = 4'(STABLE_FRAMES);
  localparam logic [3:0]  MISMATCH_W = 4'(MISMATCH_FRAMES);
  localparam logic [20:0] PCNT_TOL_W = 21'(PCNT_TOL);

  state_e      state_q, state_d;
  logic        frame_change_d_q;
  logic        ref_valid_q, ref_valid_d;
  logic [10:0] ref_vtotal_q, ref_vtotal_d;
  logic        ref_il_q, ref_il_d;
  logic [19:0] ref_pcnt_q, ref_pcnt_d;
  logic [3:0]  stable_cnt_q, stable_cnt_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;
  logic [10:0] lock_vtotal_q, lock_vtotal_d;
  logic        lock_il_q, lock_il_d;
  logic [19:0] lock_pcnt_q, lock_pcnt_d;
  logic        irq_q, irq_set;
  logic        busy_q, busy_d;
  logic        done_q;
  logic        commit_exec;
  logic [31:0] shadow_q [4];
  logic [31:0] active_q [4];

  logic               tick;
  logic signed [20:0] pcnt_diff;
  logic        [20:0] pcnt_abs;
  logic               match;

  assign tick      = frame_change_i & ~frame_change_d_q;
  // Zero-extended 21-bit signed difference cannot wrap for 20-bit operands.
  assign pcnt_diff = $signed({1'b0, pcnt_field_i}) - $signed({1'b0, ref_pcnt_q});
  assign pcnt_abs  = pcnt_diff[20] ? 21'(-pcnt_diff) : 21'(pcnt_diff);
  assign match     = (vtotal_i == ref_vtotal_q) && (interlace_flag_i == ref_il_q)
                     && (pcnt_abs <= PCNT_TOL_W);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d      = state_q;
    ref_valid_d  = ref_valid_q;
    ref_vtotal_d = ref_vtotal_q;
    ref_il_d     = ref_il_q;
    ref_pcnt_d   = ref_pcnt_q;
    stable_cnt_d = stable_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    lock_vtotal_d = lock_vtotal_q;
    lock_il_d     = lock_il_q;
    lock_pcnt_d   = lock_pcnt_q;
    irq_set      = 1'b0;

    if (!sync_active_i) begin
      state_d      = NOSYNC;
      stable_cnt_d = '0;
      miss_cnt_d   = '0;
      ref_valid_d  = 1'b0;
      irq_set      = (state_q == LOCKED);
    end else begin
      unique case (state_q)
        NOSYNC: state_d = ACQUIRE;
        ACQUIRE: begin
          if (tick) begin
            if (!ref_valid_q || !match) begin
              ref_valid_d  = 1'b1;
              ref_vtotal_d = vtotal_i;
              ref_il_d     = interlace_flag_i;
              ref_pcnt_d   = pcnt_field_i;
              stable_cnt_d = 4'd1;
            end else begin
              stable_cnt_d = stable_cnt_q + 4'd1;
              if (stable_cnt_d == STABLE_W) begin
                state_d       = LOCKED;
                lock_vtotal_d = ref_vtotal_q;
                lock_il_d     = ref_il_q;
                lock_pcnt_d   = ref_pcnt_q;
                miss_cnt_d    = '0;
                irq_set       = 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          if (tick) begin
            if (match) begin
              miss_cnt_d = '0;
            end else if (miss_cnt_q + 4'd1 == MISMATCH_W) begin
              state_d      = ACQUIRE;
              ref_vtotal_d = vtotal_i;
              ref_il_d     = interlace_flag_i;
              ref_pcnt_d   = pcnt_field_i;
              stable_cnt_d = 4'd1;
              miss_cnt_d   = '0;
              irq_set      = 1'b1;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = NOSYNC;
      endcase
    end
  end

  // Outside LOCKED a pending commit runs immediately; in LOCKED it waits for a frame boundary.
  assign commit_exec = busy_q && ((state_q != LOCKED) || tick);

  always_comb begin
    busy_d = busy_q;
    if (commit_exec)                busy_d = 1'b0;
    else if (!busy_q && commit_req_i) busy_d = 1'b1;
  end

  always_ff @(posedge PCLK_i or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset_n) begin
      state_q          <= NOSYNC;
      frame_change_d_q <= 1'b0;
      ref_valid_q      <= 1'b0;
      ref_vtotal_q     <= '0;
      ref_il_q         <= 1'b0;
      ref_pcnt_q       <= '0;
      stable_cnt_q     <= '0;
      miss_cnt_q       <= '0;
      lock_vtotal_q    <= '0;
      lock_il_q        <= 1'b0;
      lock_pcnt_q      <= '0;
      irq_q            <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      frame_change_d_q <= frame_change_i;
      ref_valid_q      <= ref_valid_d;
      ref_vtotal_q     <= ref_vtotal_d;
      ref_il_q         <= ref_il_d;
      ref_pcnt_q       <= ref_pcnt_d;
      stable_cnt_q     <= stable_cnt_d;
      miss_cnt_q       <= miss_cnt_d;
      lock_vtotal_q    <= lock_vtotal_d;
      lock_il_q        <= lock_il_d;
      lock_pcnt_q      <= lock_pcnt_d;
      irq_q            <= irq_set ? 1'b1 : (irq_clr_i ? 1'b0 : irq_q);
      busy_q           <= busy_d;
      done_q           <= commit_exec;
    end
  end

  always_ff @(posedge PCLK_i or negedge reset_n) begin
    // NOTE: these small register files are reset because software expects defined zeros after reset.
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (commit_exec) begin
        for (int i = 0; i < 4; i++) active_q[i] <= shadow_q[i];
      end
      if (cfg_wr_i) shadow_q[cfg_sel_i] <= cfg_data_i;
    end
  end

`ifdef FRONTEND_MODE_CTRL_AUTO_BLANK_EN
  logic blank_q;
  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) blank_q <= 1'b1;
    else          blank_q <= (state_d != LOCKED) || busy_d;
  end
  assign blank_o = blank_q;
`endif

  assign hv_in_config_o    = active_q[0];
  assign hv_in_config2_o   = active_q[1];
  assign hv_in_config3_o   = active_q[2];
  assign misc_config_o     = active_q[3];
  assign commit_busy_o     = busy_q;
  assign commit_done_o     = done_q;
  assign state_o           = state_q;
  assign irq_o             = irq_q;
  assign lock_vtotal_o     = lock_vtotal_q;
  assign lock_interlace_o  = lock_il_q;
  assign lock_pcnt_field_o = lock_pcnt_q;

endmodule

// File: tb/tb_frontend_mode_ctrl.sv
// Scoreboard bench for frontend_mode_ctrl: expectations queued with stimulus, drained after each DUT update.
module tb_frontend_mode_ctrl;

  logic        PCLK_i = 1'b0;
  logic        reset_n;
  logic        frame_change_i, sync_active_i, interlace_flag_i;
  logic [10:0] vtotal_i;
  logic [19:0] pcnt_field_i;
  logic        cfg_wr_i;
  logic [1:0]  cfg_sel_i;
  logic [31:0] cfg_data_i;
  logic        commit_req_i, irq_clr_i;
  logic [31:0] hv_in_config_o, hv_in_config2_o, hv_in_config3_o, misc_config_o;
  logic        commit_busy_o, commit_done_o, irq_o, lock_interlace_o;
  logic [1:0]  state_o;
  logic [10:0] lock_vtotal_o;
  logic [19:0] lock_pcnt_field_o;

  frontend_mode_ctrl dut (
    .PCLK_i(PCLK_i), .reset_n(reset_n), .frame_change_i(frame_change_i),
    .sync_active_i(sync_active_i), .interlace_flag_i(interlace_flag_i),
    .vtotal_i(vtotal_i), .pcnt_field_i(pcnt_field_i), .cfg_wr_i(cfg_wr_i),
    .cfg_sel_i(cfg_sel_i), .cfg_data_i(cfg_data_i), .commit_req_i(commit_req_i),
    .irq_clr_i(irq_clr_i), .hv_in_config_o(hv_in_config_o),
    .hv_in_config2_o(hv_in_config2_o), .hv_in_config3_o(hv_in_config3_o),
    .misc_config_o(misc_config_o), .commit_busy_o(commit_busy_o),
    .commit_done_o(commit_done_o), .state_o(state_o), .irq_o(irq_o),
    .lock_vtotal_o(lock_vtotal_o), .lock_interlace_o(lock_interlace_o),
    .lock_pcnt_field_o(lock_pcnt_field_o)
  );

  always #5 PCLK_i = ~PCLK_i;

  typedef enum int {S_STATE, S_IRQ, S_BUSY, S_DONE, S_HV1, S_HV2, S_HV3, S_MISC,
                    S_LVT, S_LIL, S_LPC, S_DONECNT} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  always @(negedge PCLK_i) if (commit_done_o === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      S_STATE:   return 32'(state_o);
      S_IRQ:     return 32'(irq_o);
      S_BUSY:    return 32'(commit_busy_o);
      S_DONE:    return 32'(commit_done_o);
      S_HV1:     return hv_in_config_o;
      S_HV2:     return hv_in_config2_o;
      S_HV3:     return hv_in_config3_o;
      S_MISC:    return misc_config_o;
      S_LVT:     return 32'(lock_vtotal_o);
      S_LIL:     return 32'(lock_interlace_o);
      S_LPC:     return 32'(lock_pcnt_field_o);
      default:   return 32'(done_cnt);
    endcase
  endfunction

  task automatic push(input string tag, input sig_e s, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sig = s; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, actual(e.sig), e.exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK_i);
    #1;
  endtask

  task automatic set_meas(input logic [10:0] vt, input logic il, input logic [19:0] pc);
    vtotal_i = vt; interlace_flag_i = il; pcnt_field_i = pc;
  endtask

  // One frame: rising frame_change edge (tick sampled on the first clock), then low.
  task automatic frame(input logic [10:0] vt, input logic il, input logic [19:0] pc);
    set_meas(vt, il, pc);
    frame_change_i = 1'b1;
    step();
    frame_change_i = 1'b0;
    step();
  endtask

  task automatic push_all_zero(input string pfx);
    push({pfx, "_state"}, S_STATE, 0);
    push({pfx, "_irq"},   S_IRQ,   0);
    push({pfx, "_busy"},  S_BUSY,  0);
    push({pfx, "_done"},  S_DONE,  0);
    push({pfx, "_hv1"},   S_HV1,   0);
    push({pfx, "_hv2"},   S_HV2,   0);
    push({pfx, "_hv3"},   S_HV3,   0);
    push({pfx, "_misc"},  S_MISC,  0);
    push({pfx, "_lvt"},   S_LVT,   0);
    push({pfx, "_lil"},   S_LIL,   0);
    push({pfx, "_lpc"},   S_LPC,   0);
  endtask

  task automatic acquire_lock(input logic [19:0] pc);
    for (int i = 0; i < 3; i++) begin
      frame(11'd525, 1'b1, pc);
      push($sformatf("acq_frame%0d_state", i + 1), S_STATE, 1);
      drain();
    end
    frame(11'd525, 1'b1, pc);
    push("lock_state", S_STATE, 2);
    push("lock_irq", S_IRQ, 1);
    push("lock_vtotal", S_LVT, 525);
    push("lock_il", S_LIL, 1);
    push("lock_pcnt", S_LPC, 32'(pc));
    drain();
  endtask

  task automatic clear_irq();
    irq_clr_i = 1'b1;
    step();
    irq_clr_i = 1'b0;
    push("irq_cleared", S_IRQ, 0);
    drain();
  endtask

  initial begin
    reset_n = 1'b0;
    frame_change_i = 0; sync_active_i = 0; interlace_flag_i = 0;
    vtotal_i = '0; pcnt_field_i = '0;
    cfg_wr_i = 0; cfg_sel_i = '0; cfg_data_i = '0;
    commit_req_i = 0; irq_clr_i = 0;
    repeat (3) step();
    push_all_zero("reset");
    drain();
    reset_n = 1'b1;
    step();

    // Lock acquisition
    sync_active_i = 1'b1;
    step();
    push("nosync_to_acquire", S_STATE, 1);
    drain();
    acquire_lock(20'd429000);
    clear_irq();

    // Tolerance: +63, +64 still match; two frames at +100 drop lock
    frame(11'd525, 1'b1, 20'd429063);
    push("tol_p63_state", S_STATE, 2);
    drain();
    frame(11'd525, 1'b1, 20'd429064);
    push("tol_p64_state", S_STATE, 2);
    drain();
    frame(11'd525, 1'b1, 20'd429100);
    push("miss1_state", S_STATE, 2);
    push("miss1_irq", S_IRQ, 0);
    drain();
    frame(11'd525, 1'b1, 20'd429100);
    push("miss2_state", S_STATE, 1);
    push("miss2_irq", S_IRQ, 1);
    drain();
    clear_irq();

    // Relock on recaptured reference (429100 already counts as first frame)
    for (int i = 0; i < 2; i++) frame(11'd525, 1'b1, 20'd429100);
    push("relock_pre_state", S_STATE, 1);
    drain();
    frame(11'd525, 1'b1, 20'd429100);
    push("relock_state", S_STATE, 2);
    push("relock_pcnt", S_LPC, 429100);
    drain();
    clear_irq();

    // Lower tolerance boundary and miss counter reset on match
    frame(11'd525, 1'b1, 20'd429036);
    push("tol_m64_state", S_STATE, 2);
    drain();
    frame(11'd525, 1'b1, 20'd429035);
    frame(11'd525, 1'b1, 20'd429100);
    frame(11'd525, 1'b1, 20'd429035);
    push("miss_reset_state", S_STATE, 2);
    push("miss_reset_irq", S_IRQ, 0);
    drain();
    frame(11'd524, 1'b1, 20'd429100);
    push("vtotal_miss_state", S_STATE, 1);
    drain();
    frame(11'd525, 1'b1, 20'd429100);
    frame(11'd525, 1'b1, 20'd429100);
    frame(11'd525, 1'b1, 20'd429100);
    frame(11'd525, 1'b1, 20'd429100);
    push("relock2_state", S_STATE, 2);
    drain();
    clear_irq();

    // Frame-aligned commit while locked
    cfg_wr_i = 1'b1; cfg_sel_i = 2'd0; cfg_data_i = 32'h2050_0360;
    step();
    cfg_wr_i = 1'b0;
    commit_req_i = 1'b1;
    step();
    commit_req_i = 1'b0;
    push("lk_busy_set", S_BUSY, 1);
    push("lk_hv_hold", S_HV1, 0);
    drain();
    repeat (4) step();
    push("lk_busy_wait", S_BUSY, 1);
    push("lk_hv_wait", S_HV1, 0);
    push("lk_done_wait", S_DONECNT, 0);
    drain();
    set_meas(11'd525, 1'b1, 20'd429100);
    frame_change_i = 1'b1;
    cfg_wr_i = 1'b1; cfg_sel_i = 2'd0; cfg_data_i = 32'h1111_1111;
    step();
    cfg_wr_i = 1'b0;
    frame_change_i = 1'b0;
    push("lk_done_pulse", S_DONE, 1);
    push("lk_hv_applied", S_HV1, 32'h2050_0360);
    push("lk_busy_clr", S_BUSY, 0);
    drain();
    step();
    push("lk_done_low", S_DONE, 0);
    push("lk_hv_stays", S_HV1, 32'h2050_0360);
    push("lk_done_count", S_DONECNT, 1);
    drain();

    // Sync loss with simultaneous irq clear
    sync_active_i = 1'b0;
    irq_clr_i = 1'b1;
    step();
    irq_clr_i = 1'b0;
    push("loss_state", S_STATE, 0);
    push("loss_irq_wins", S_IRQ, 1);
    push("loss_lock_hold", S_LVT, 525);
    drain();
    clear_irq();

    // Unlocked commit; second request while busy is ignored
    cfg_wr_i = 1'b1; cfg_sel_i = 2'd3; cfg_data_i = 32'h0000_0080;
    step();
    cfg_wr_i = 1'b0;
    commit_req_i = 1'b1;
    step();
    push("ul_busy", S_BUSY, 1);
    push("ul_misc_hold", S_MISC, 0);
    drain();
    step();
    commit_req_i = 1'b0;
    push("ul_misc_applied", S_MISC, 32'h80);
    push("ul_hv_shadow", S_HV1, 32'h1111_1111);
    push("ul_done", S_DONE, 1);
    push("ul_busy_clr", S_BUSY, 0);
    drain();
    repeat (3) step();
    push("ul_done_count", S_DONECNT, 2);
    push("ul_busy_idle", S_BUSY, 0);
    drain();

    // Reset mid-commit
    sync_active_i = 1'b1;
    step();
    acquire_lock(20'd429000);
    cfg_wr_i = 1'b1; cfg_sel_i = 2'd1; cfg_data_i = 32'hDEAD_BEEF;
    step();
    cfg_wr_i = 1'b0;
    commit_req_i = 1'b1;
    step();
    commit_req_i = 1'b0;
    push("rst_pre_busy", S_BUSY, 1);
    drain();
    reset_n = 1'b0;
    step();
    push_all_zero("midrst");
    drain();
    reset_n = 1'b1;
    sync_active_i = 1'b0;
    frame(11'd525, 1'b1, 20'd429000);
    repeat (3) step();
    push("post_rst_done_count", S_DONECNT, 2);
    push("post_rst_hv2", S_HV2, 0);
    push("post_rst_busy", S_BUSY, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
